// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator.
// Mode encodings and the 2-bit mode type.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FADE  = 2'd3
    } mode_t;

    localparam mode_t MODE_RESET = MODE_COUNT;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: free-running divide-by-DIV while run=1,
// single-step pulses while run=0.
module tick_prescaler #(
    parameter int DIV = 4194304
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic step,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (run) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Prescaler frozen; each step pulse becomes one tick.
            tick_d = step;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, SCAN, BLINK and FADE patterns
// advanced once per prescaler tick.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV    = 4194304,
    parameter int PWM_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              tick,
    output logic [1:0]        mode_active
);

    localparam logic [N_LEDS-1:0] SCAN_INIT = N_LEDS'(1);
    localparam logic [PWM_W-1:0]  DUTY_MAX  = '1;

    logic              tick_w;
    mode_t             mode_req;

    mode_t             act_q, act_d;
    logic [N_LEDS-1:0] count_q, count_d;
    logic [N_LEDS-1:0] scan_q, scan_d;
    logic              scan_up_q, scan_up_d;
    logic              blink_q, blink_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic              duty_up_q, duty_up_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [N_LEDS-1:0] led_q, led_d;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .step   (step),
        .tick   (tick_w)
    );

    assign mode_req = mode_t'(mode);

    always_comb begin
        act_d     = act_q;
        count_d   = count_q;
        scan_d    = scan_q;
        scan_up_d = scan_up_q;
        blink_d   = blink_q;
        duty_d    = duty_q;
        duty_up_d = duty_up_q;
        pwm_d     = pwm_q + PWM_W'(1);
        led_d     = '0;

        if (tick_w) begin
            if (mode_req != act_q) begin
                // A mode change restarts the new pattern instead of advancing.
                act_d = mode_req;
                unique case (mode_req)
                    MODE_COUNT: count_d = '0;
                    MODE_SCAN: begin
                        scan_d    = SCAN_INIT;
                        scan_up_d = 1'b1;
                    end
                    MODE_BLINK: blink_d = 1'b0;
                    MODE_FADE: begin
                        duty_d    = '0;
                        duty_up_d = 1'b1;
                    end
                endcase
            end else begin
                unique case (act_q)
                    MODE_COUNT: count_d = count_q + N_LEDS'(1);
                    MODE_SCAN: begin
                        if (scan_up_q) begin
                            if (scan_q[N_LEDS-1]) begin
                                scan_up_d = 1'b0;
                                scan_d    = scan_q >> 1;
                            end else begin
                                scan_d = scan_q << 1;
                            end
                        end else begin
                            if (scan_q[0]) begin
                                scan_up_d = 1'b1;
                                scan_d    = scan_q << 1;
                            end else begin
                                scan_d = scan_q >> 1;
                            end
                        end
                    end
                    MODE_BLINK: blink_d = ~blink_q;
                    MODE_FADE: begin
                        if (duty_up_q) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_up_d = 1'b0;
                                duty_d    = duty_q - PWM_W'(1);
                            end else begin
                                duty_d = duty_q + PWM_W'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_up_d = 1'b1;
                                duty_d    = duty_q + PWM_W'(1);
                            end else begin
                                duty_d = duty_q - PWM_W'(1);
                            end
                        end
                    end
                endcase
            end
        end

        // LED drive is registered from the next-state pattern values.
        unique case (act_d)
            MODE_COUNT: led_d = count_d;
            MODE_SCAN:  led_d = scan_d;
            MODE_BLINK: led_d = {N_LEDS{blink_d}};
            MODE_FADE:  led_d = {N_LEDS{pwm_d < duty_d}};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_q     <= MODE_RESET;
            count_q   <= '0;
            scan_q    <= SCAN_INIT;
            scan_up_q <= 1'b1;
            blink_q   <= 1'b0;
            duty_q    <= '0;
            duty_up_q <= 1'b1;
            pwm_q     <= '0;
            led_q     <= '0;
        end else begin
            act_q     <= act_d;
            count_q   <= count_d;
            scan_q    <= scan_d;
            scan_up_q <= scan_up_d;
            blink_q   <= blink_d;
            duty_q    <= duty_d;
            duty_up_q <= duty_up_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
        end
    end

    assign led         = led_q;
    assign tick        = tick_w;
    assign mode_active = act_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed scoreboard bench for led_pattern_gen
// (DIV=4, N_LEDS=8, PWM_W=4).
module tb_led_pattern_gen;

    localparam int N_LEDS = 8;
    localparam int DIV    = 4;
    localparam int PWM_W  = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              run;
    logic              step;
    logic [1:0]        mode;
    logic [N_LEDS-1:0] led;
    logic              tick;
    logic [1:0]        mode_active;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_cnt = 0;

    logic [7:0] exp_q[$];

    logic [7:0] scan_seq [17] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
        8'h04
    };

    led_pattern_gen #(
        .N_LEDS (N_LEDS),
        .DIV    (DIV),
        .PWM_W  (PWM_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .step        (step),
        .mode        (mode),
        .led         (led),
        .tick        (tick),
        .mode_active (mode_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick === 1'b1) tick_cnt <= tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!found) chk("tick_timeout", 32'(found), 32'd1);
    endtask

    task automatic tick_then_led(input string tag);
        int t;
        logic [7:0] e;
        wait_tick(t);
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk(tag, 32'(led), 32'(e));
    endtask

    task automatic advance(input int n);
        int t;
        for (int i = 0; i < n; i++) wait_tick(t);
        @(negedge clk);
    endtask

    task automatic duty_window(input string tag, input int exp_on);
        int on = 0;
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led === 8'hFF) on++;
        end
        chk(tag, 32'(on), 32'(exp_on));
        run = 1'b1;
    endtask

    initial begin
        int t, prev, rel, tc0;

        resetn = 1'b0;
        run    = 1'b0;
        step   = 1'b0;
        mode   = 2'd0;
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_mode", 32'(mode_active), 32'h0);

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        run    = 1'b1;
        rel    = cyc;
        prev   = 0;

        // COUNT across a full wrap
        for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 256; i++) begin
            wait_tick(t);
            if (i == 0) chk("first_tick_lat", 32'(t - rel), 32'(DIV));
            else chk("tick_period", 32'(t - prev), 32'(DIV));
            prev = t;
            @(negedge clk);
            chk("count", 32'(led), 32'(exp_q.pop_front()));
        end

        // SCAN bounce
        mode = 2'd1;
        foreach (scan_seq[i]) exp_q.push_back(scan_seq[i]);
        for (int i = 0; i < 17; i++) tick_then_led("scan");
        chk("scan_mode", 32'(mode_active), 32'd1);

        // Single steps with the prescaler frozen
        run = 1'b0;
        tc0 = tick_cnt;
        repeat (8) @(negedge clk);
        chk("frozen_no_tick", 32'(tick_cnt - tc0), 32'd0);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
            chk("step_adv", 32'(led), 32'(exp_q.pop_front()));
        end
        chk("step_ticks", 32'(tick_cnt - tc0), 32'd3);

        step = 1'b1;
        run  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_ignored_run", 32'(tick), 32'd0);
        exp_q.push_back(8'h40);
        tick_then_led("run_resume");
        chk("step_total_ticks", 32'(tick_cnt - tc0), 32'd4);

        // Mode switch 0 -> 2 mid-period
        mode = 2'd0;
        exp_q.push_back(8'h00);
        tick_then_led("to_count");
        chk("count_mode", 32'(mode_active), 32'd0);
        mode = 2'd2;
        @(negedge clk);
        chk("mode_hold", 32'(mode_active), 32'd0);
        chk("mode_hold_led", 32'(led), 32'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        tick_then_led("blink_load");
        chk("blink_mode", 32'(mode_active), 32'd2);
        tick_then_led("blink_on");
        tick_then_led("blink_off");

        // FADE duty ramp
        mode = 2'd3;
        exp_q.push_back(8'h00);
        tick_then_led("fade_load");
        chk("fade_mode", 32'(mode_active), 32'd3);
        duty_window("duty0", 0);
        advance(8);
        duty_window("duty8", 8);
        advance(7);
        duty_window("duty15", 15);
        advance(15);
        duty_window("duty0_down", 0);
        advance(1);
        duty_window("duty1_up", 1);

        // Asynchronous reset mid-COUNT with a step pending
        mode = 2'd0;
        advance(1);
        chk("count_reload", 32'(led), 32'h00);
        advance(8'h5A);
        chk("count_5a", 32'(led), 32'h5A);
        run  = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_mode", 32'(mode_active), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tc0 = tick_cnt;
        repeat (4) @(negedge clk);
        chk("no_pending_tick", 32'(tick_cnt - tc0), 32'd0);
        chk("post_rst_led", 32'(led), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
